// File: rtl/stack_arbiter.sv
// Round-robin arbiter and sequencer sharing one hardware stack
// between the CPU datapath (port A) and the trap unit (port B).
module stack_arbiter #(
  parameter int W     = 10,
  parameter int DEPTH = 7,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_op,
  input  logic [W-1:0]  a_wdata,
  output logic          a_ack,
  output logic          a_err,
  output logic [W-1:0]  a_rdata,
  input  logic          b_req,
  input  logic          b_op,
  input  logic [W-1:0]  b_wdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [W-1:0]  b_rdata,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [W-1:0]  stk_wdata,
  input  logic [W-1:0]  stk_rdata,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf,
  input  logic          clr_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK
  } state_t;

  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  state_t        state;
  state_t        state_nxt;
  logic          gnt_b;
  logic          last_b;
  logic          op_q;
  logic          err_q;
  logic [W-1:0]  data_q;
  logic          any_req;
  logic          pick_b;
  logic          in_issue;
  logic          in_ack;
  logic          legal;
  logic          bad;

  assign any_req  = a_req | b_req;
  assign pick_b   = b_req & (~a_req | ~last_b);
  assign in_issue = (state == ISSUE);
  assign in_ack   = (state == ACK);
  assign legal    = op_q ? (depth != '0)
                         : (depth != DMAX);
  assign bad      = in_issue & ~legal;

  assign stk_push  = in_issue & ~op_q & legal;
  assign stk_pop   = in_issue & op_q & legal;
  assign stk_wdata = in_issue ? data_q : '0;

  assign a_ack = in_ack & ~gnt_b;
  assign b_ack = in_ack & gnt_b;
  assign a_err = a_ack & err_q;
  assign b_err = b_ack & err_q;

  assign full  = (depth == DMAX);
  assign empty = (depth == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: one cycle each in ISSUE and ACK
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and latch winner's op/data; last_b starts at B so A wins first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_b  <= 1'b0;
      last_b <= 1'b1;
      op_q   <= 1'b0;
      data_q <= '0;
    end else if (state == IDLE && any_req) begin
      gnt_b  <= pick_b;
      last_b <= pick_b;
      op_q   <= pick_b ? b_op : a_op;
      data_q <= pick_b ? b_wdata : a_wdata;
    end
  end

  // Depth tracking and error flag, only touched in ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
      err_q <= 1'b0;
    end else if (in_issue) begin
      err_q <= ~legal;
      if (stk_push)     depth <= depth + 1'b1;
      else if (stk_pop) depth <= depth - 1'b1;
    end
  end

  // Pop results land in the winner's register only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (stk_pop) begin
      if (gnt_b) b_rdata <= stk_rdata;
      else       a_rdata <= stk_rdata;
    end
  end

  // Sticky flags; a new error beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (clr_err) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (bad && !op_q) ovf <= 1'b1;
      if (bad && op_q)  unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a small
// behavioural stack hanging off the stk_* port.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 0, a_op = 0, b_req = 0, b_op = 0;
  logic [9:0] a_wdata = 0, b_wdata = 0;
  logic       a_ack, a_err, b_ack, b_err;
  logic [9:0] a_rdata, b_rdata;
  logic       stk_push, stk_pop;
  logic [9:0] stk_wdata, stk_rdata;
  logic [2:0] depth;
  logic       full, empty, ovf, unf;
  logic       clr_err = 0;

  int passed = 0;
  int total  = 0;

  logic       o_push, o_pop, o_ack, o_err, o_other;
  logic [9:0] o_wdata, o_rdata;
  logic [2:0] o_depth;
  int         o_cyc;

  logic [9:0] mem [0:7];
  logic [2:0] sp;

  stack_arbiter #(.W(10), .DEPTH(7)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .depth(depth), .full(full), .empty(empty),
    .ovf(ovf), .unf(unf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Behavioural stack sharing the arbiter's reset
  always @(posedge clk or posedge rst) begin
    if (rst) sp <= 3'd0;
    else if (stk_push) begin
      mem[sp] <= stk_wdata;
      sp <= sp + 3'd1;
    end else if (stk_pop) sp <= sp - 3'd1;
  end

  assign stk_rdata = (sp != 3'd0) ? mem[sp - 3'd1] : 10'h000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    a_req = 0; b_req = 0; clr_err = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic run_op(input logic pb, input logic op,
                        input logic [9:0] d);
    o_push = 0; o_pop = 0; o_ack = 0; o_err = 0;
    o_other = 0; o_wdata = 0; o_rdata = 0;
    o_depth = 0; o_cyc = -1;
    if (pb) begin b_req = 1; b_op = op; b_wdata = d; end
    else    begin a_req = 1; a_op = op; a_wdata = d; end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (stk_push) begin o_push = 1; o_wdata = stk_wdata; end
      if (stk_pop) o_pop = 1;
      if (pb ? a_ack : b_ack) o_other = 1;
      if (pb ? b_ack : a_ack) begin
        o_ack = 1;
        o_err = pb ? b_err : a_err;
        o_rdata = pb ? b_rdata : a_rdata;
        o_depth = depth;
        o_cyc = i;
        break;
      end
    end
    a_req = 0; b_req = 0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({depth, empty, full} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL reset_depth got d=%0d e=%b f=%b want 0 1 0", depth, empty, full);
    else passed++;
    total++;
    if ({a_ack, a_err, b_ack, b_err, stk_push, stk_pop, ovf, unf} !== 8'h00)
      $display("FAIL reset_flags got %b want 00000000",
               {a_ack, a_err, b_ack, b_err, stk_push, stk_pop, ovf, unf});
    else passed++;
    total++;
    if ({a_rdata, b_rdata, stk_wdata} !== 30'h0)
      $display("FAIL reset_data got %h %h %h want 0", a_rdata, b_rdata, stk_wdata);
    else passed++;
  endtask

  task automatic test_push_pop();
    run_op(1'b0, 1'b0, 10'h155);
    total++;
    if (!(o_push && o_wdata === 10'h155))
      $display("FAIL push_strobe got %b/%h want 1/155", o_push, o_wdata);
    else passed++;
    total++;
    if (!(o_ack && o_cyc == 2 && o_err === 1'b0))
      $display("FAIL push_ack got cyc=%0d err=%b want 2 0", o_cyc, o_err);
    else passed++;
    total++;
    if (o_depth !== 3'd1)
      $display("FAIL push_depth got %0d want 1", o_depth);
    else passed++;
    run_op(1'b0, 1'b1, 10'h000);
    total++;
    if (!(o_pop && o_ack && o_rdata === 10'h155 && o_depth === 3'd0))
      $display("FAIL pop got pop=%b rd=%h d=%0d want 1 155 0", o_pop, o_rdata, o_depth);
    else passed++;
    total++;
    if (!(a_rdata === 10'h155 && empty === 1'b1))
      $display("FAIL pop_hold got %h e=%b want 155 1", a_rdata, empty);
    else passed++;
  endtask

  task automatic test_underflow();
    run_op(1'b0, 1'b1, 10'h000);
    total++;
    if (!(o_ack && !o_pop && o_err === 1'b1))
      $display("FAIL unf_op got ack=%b pop=%b err=%b want 1 0 1", o_ack, o_pop, o_err);
    else passed++;
    total++;
    if (!(unf === 1'b1 && ovf === 1'b0 && depth === 3'd0))
      $display("FAIL unf_flag got unf=%b ovf=%b d=%0d want 1 0 0", unf, ovf, depth);
    else passed++;
    total++;
    if (o_rdata !== 10'h155)
      $display("FAIL unf_rdata got %h want 155", o_rdata);
    else passed++;
    clr_err = 1;
    tick();
    clr_err = 0;
    total++;
    if (unf !== 1'b0)
      $display("FAIL unf_clear got %b want 0", unf);
    else passed++;
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 7; k++) begin
      run_op(1'b1, 1'b0, 10'(k));
      total++;
      if (!(o_push && o_ack && !o_err && o_wdata === 10'(k)))
        $display("FAIL fill_%0d got push=%b err=%b wd=%h", k, o_push, o_err, o_wdata);
      else passed++;
    end
    total++;
    if (!(full === 1'b1 && depth === 3'd7))
      $display("FAIL full got f=%b d=%0d want 1 7", full, depth);
    else passed++;
    run_op(1'b1, 1'b0, 10'h008);
    total++;
    if (!(o_ack && !o_push && o_err === 1'b1))
      $display("FAIL ovf_op got ack=%b push=%b err=%b want 1 0 1", o_ack, o_push, o_err);
    else passed++;
    total++;
    if (!(ovf === 1'b1 && depth === 3'd7 && sp === 3'd7))
      $display("FAIL ovf_flag got ovf=%b d=%0d want 1 7", ovf, depth);
    else passed++;
    total++;
    if (o_other !== 1'b0 || a_rdata !== 10'h155)
      $display("FAIL loser_quiet got ack=%b rd=%h want 0 155", o_other, a_rdata);
    else passed++;
    run_op(1'b1, 1'b1, 10'h000);
    total++;
    if (!(o_rdata === 10'h007 && o_depth === 3'd6 && full === 1'b0))
      $display("FAIL top_pop got rd=%h d=%0d want 007 6", o_rdata, o_depth);
    else passed++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    a_req = 1; a_op = 0; a_wdata = 10'h0AA;
    b_req = 1; b_op = 0; b_wdata = 10'h0BB;
    tick();
    total++;
    if (!(stk_push && stk_wdata === 10'h0AA))
      $display("FAIL rr_first got %b/%h want 1/0aa", stk_push, stk_wdata);
    else passed++;
    tick();
    total++;
    if ({a_ack, b_ack} !== 2'b10)
      $display("FAIL rr_ack_a got %b want 10", {a_ack, b_ack});
    else passed++;
    a_req = 0;
    tick();
    tick();
    total++;
    if (!(stk_push && stk_wdata === 10'h0BB))
      $display("FAIL rr_second got %b/%h want 1/0bb", stk_push, stk_wdata);
    else passed++;
    tick();
    total++;
    if ({a_ack, b_ack} !== 2'b01)
      $display("FAIL rr_ack_b got %b want 01", {a_ack, b_ack});
    else passed++;
    b_req = 0;
    tick();
    run_op(1'b0, 1'b1, 10'h000);
    total++;
    if (o_rdata !== 10'h0BB)
      $display("FAIL rr_pop1 got %h want 0bb", o_rdata);
    else passed++;
    run_op(1'b1, 1'b1, 10'h000);
    total++;
    if (!(o_rdata === 10'h0AA && empty === 1'b1))
      $display("FAIL rr_pop2 got %h e=%b want 0aa 1", o_rdata, empty);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    int acks;
    acks = 0;
    a_req = 1; a_op = 0; a_wdata = 10'h123;
    tick();
    rst = 1;
    #1;
    total++;
    if ({stk_push, depth} !== 4'b0000)
      $display("FAIL rst_mid got push=%b d=%0d want 0 0", stk_push, depth);
    else passed++;
    tick();
    rst = 0;
    a_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_ack || b_ack) acks++;
    end
    total++;
    if (!(acks == 0 && depth === 3'd0 && empty === 1'b1))
      $display("FAIL rst_noack got acks=%0d d=%0d want 0 0", acks, depth);
    else passed++;
    run_op(1'b0, 1'b0, 10'h123);
    total++;
    if (!(o_cyc == 2 && o_push && o_depth === 3'd1))
      $display("FAIL rst_retry got cyc=%0d d=%0d want 2 1", o_cyc, o_depth);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_round_robin();
    apply_reset();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
